// File: rtl/grant_decoder_2to4.sv
// grant_decoder_2to4: decodes an accepted 2-bit request code into a held one-hot grant.
// Define GRANT_TIMEOUT_EN to build the hold counter and the auto-release timeout.
module grant_decoder_2to4 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] grant,
    output logic       grant_valid,
    input  logic       ack,
    output logic       timeout,
    output logic [1:0] last_code
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Reject an unreachable or unrepresentable hold limit at elaboration.
    if (HOLD_MAX < 1 || HOLD_MAX > (1 << CNT_W)) begin : g_bad_hold_max
        $error("grant_decoder_2to4: HOLD_MAX out of range for CNT_W");
    end

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic       gv_q, gv_d;
    logic [1:0] code_q, code_d;

`ifdef GRANT_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            gv_q    <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        code_d  = code_q;
`ifdef GRANT_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    code_d  = in_code;
                    grant_d = 4'b0001 << in_code;
                    gv_d    = 1'b1;
                    state_d = GRANT;
`ifdef GRANT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                // ack takes priority over an expiring hold counter
                if (ack) begin
                    grant_d = 4'b0000;
                    gv_d    = 1'b0;
                    state_d = RELEASE;
                end
`ifdef GRANT_TIMEOUT_EN
                else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    grant_d = 4'b0000;
                    gv_d    = 1'b0;
                    to_d    = 1'b1;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                gv_d    = 1'b0;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign grant       = grant_q;
    assign grant_valid = gv_q;
    assign last_code   = code_q;

endmodule
